// File: rtl/core_sleep_pkg.sv
// core_sleep_pkg: shared types and defaults for the core sleep/wake controller.
//   state_e          - controller FSM states
//   DEF_*            - default parameter values
//   eff_wake_delay() - WAKE dwell length, with a request of 0 promoted to 1
package core_sleep_pkg;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_WAKE  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_SLEEP = 3'd4
  } state_e;

  localparam int DEF_MAX_OUTSTANDING = 2;
  localparam int DEF_WAKE_DELAY      = 2;

  function automatic int eff_wake_delay(input int d);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/core_sleep_otx_cnt.sv
// core_sleep_otx_cnt: outstanding-transaction counter for one OBI bus.
//   clk_i, rst_ni - ungated clock, async active-low reset
//   i_req/i_gnt   - address phase handshake (accepted on req&gnt)
//   i_rvalid      - response phase
//   o_cnt_nxt     - count after the current edge (lets the top see a
//                   response that empties the bus in the same cycle)
//   o_err         - sticky over/underflow flag, cleared only by reset
module core_sleep_otx_cnt
  import core_sleep_pkg::*;
#(
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int CW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          i_req,
  input  logic          i_gnt,
  input  logic          i_rvalid,
  output logic [CW-1:0] o_cnt_nxt,
  output logic          o_err
);

  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);

  logic [CW-1:0] r_cnt;
  logic          r_err;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_inc;
  logic          w_ovf;
  logic          w_unf;

  assign w_inc = i_req & i_gnt;

  // A grant and a response together cancel out, even at the limits.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_ovf     = 1'b0;
    w_unf     = 1'b0;
    if (w_inc && !i_rvalid) begin
      if (r_cnt == MAX_C) w_ovf     = 1'b1;
      else                w_cnt_nxt = r_cnt + 1'b1;
    end else if (!w_inc && i_rvalid) begin
      if (r_cnt == '0) w_unf     = 1'b1;
      else             w_cnt_nxt = r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_err <= r_err | w_ovf | w_unf;
    end
  end

  assign o_cnt_nxt = w_cnt_nxt;
  assign o_err     = r_err;

endmodule

// File: rtl/core_sleep_ctrl.sv
// core_sleep_ctrl: sleep/wake controller driving the core clock gate enable.
// Runs on the ungated clock.
//   clk_i, rst_ni            - ungated clock, async active-low reset
//   fetch_enable_i           - external fetch enable (effectively sticky)
//   wfi_i                    - core has retired WFI, requests sleep
//   irq_pending_i            - enabled interrupt pending (wake source)
//   debug_req_i              - debug request (wake source)
//   instr_req/gnt/rvalid_i   - instruction bus handshake
//   data_req/gnt/rvalid_i    - data bus handshake
//   clock_en_o               - registered enable to the clock gate
//   core_sleep_o             - core clock stopped
//   fetch_enable_o           - fetch enable to core
//   wake_o                   - one-cycle pulse on SLEEP->WAKE
//   err_o                    - sticky bus counter over/underflow
module core_sleep_ctrl
  import core_sleep_pkg::*;
#(
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int WAKE_DELAY      = DEF_WAKE_DELAY
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic fetch_enable_i,
  input  logic wfi_i,
  input  logic irq_pending_i,
  input  logic debug_req_i,
  input  logic instr_req_i,
  input  logic instr_gnt_i,
  input  logic instr_rvalid_i,
  input  logic data_req_i,
  input  logic data_gnt_i,
  input  logic data_rvalid_i,
  output logic clock_en_o,
  output logic core_sleep_o,
  output logic fetch_enable_o,
  output logic wake_o,
  output logic err_o
);

  localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int DLY = eff_wake_delay(WAKE_DELAY);
  localparam int DW  = $clog2(DLY + 1);
  localparam logic [DW-1:0] DLY_C = DW'(DLY);
  localparam logic [DW-1:0] ONE_C = DW'(1);

  state_e        r_state;
  state_e        w_state_nxt;
  logic [DW-1:0] r_dly;
  logic          r_clk_en;
  logic          r_sleep;
  logic          r_fetch_en;
  logic          r_wake;

  logic [CW-1:0] w_icnt_nxt;
  logic [CW-1:0] w_dcnt_nxt;
  logic          w_ierr;
  logic          w_derr;
  logic          w_wake_evt;
  logic          w_quiet;
  logic          w_clk_en;
  logic          w_sleep;
  logic          w_fetch_en;
  logic          w_wake;

  core_sleep_otx_cnt #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_instr_cnt (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .i_req     (instr_req_i),
    .i_gnt     (instr_gnt_i),
    .i_rvalid  (instr_rvalid_i),
    .o_cnt_nxt (w_icnt_nxt),
    .o_err     (w_ierr)
  );

  core_sleep_otx_cnt #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_data_cnt (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .i_req     (data_req_i),
    .i_gnt     (data_gnt_i),
    .i_rvalid  (data_rvalid_i),
    .o_cnt_nxt (w_dcnt_nxt),
    .o_err     (w_derr)
  );

  assign w_wake_evt = irq_pending_i | debug_req_i;
  // Post-edge counts: a final response arriving this cycle already counts
  // as drained, so the gate closes on the same edge that retires it.
  assign w_quiet    = (w_icnt_nxt == '0) && (w_dcnt_nxt == '0) &&
                      !instr_req_i && !data_req_i;

  // State register, wake delay counter and registered output decode.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= ST_OFF;
      r_dly      <= '0;
      r_clk_en   <= 1'b0;
      r_sleep    <= 1'b1;
      r_fetch_en <= 1'b0;
      r_wake     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_clk_en   <= w_clk_en;
      r_sleep    <= w_sleep;
      r_fetch_en <= w_fetch_en;
      r_wake     <= w_wake;
      if (r_state != ST_WAKE && w_state_nxt == ST_WAKE) r_dly <= DLY_C;
      else if (r_state == ST_WAKE && r_dly != ONE_C)    r_dly <= r_dly - 1'b1;
    end
  end

  // OFF is only re-entered through reset, so leaving it on fetch_enable_i
  // makes the enable sticky without a separate capture flop.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_OFF:   if (fetch_enable_i) w_state_nxt = ST_WAKE;
      ST_WAKE:  if (r_dly == ONE_C) w_state_nxt = ST_RUN;
      ST_RUN:   if (wfi_i && !w_wake_evt) w_state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (w_wake_evt)   w_state_nxt = ST_RUN;
        else if (w_quiet) w_state_nxt = ST_SLEEP;
      end
      ST_SLEEP: if (w_wake_evt) w_state_nxt = ST_WAKE;
      default:  w_state_nxt = ST_OFF;
    endcase
  end

  always_comb begin
    w_clk_en   = 1'b0;
    w_sleep    = 1'b1;
    w_fetch_en = 1'b0;
    case (w_state_nxt)
      ST_WAKE, ST_DRAIN: begin
        w_clk_en = 1'b1;
        w_sleep  = 1'b0;
      end
      ST_RUN: begin
        w_clk_en   = 1'b1;
        w_sleep    = 1'b0;
        w_fetch_en = 1'b1;
      end
      default: ;
    endcase
    w_wake = (r_state == ST_SLEEP) && (w_state_nxt == ST_WAKE);
  end

  assign clock_en_o     = r_clk_en;
  assign core_sleep_o   = r_sleep;
  assign fetch_enable_o = r_fetch_en;
  assign wake_o         = r_wake;
  assign err_o          = w_ierr | w_derr;

endmodule

// File: doc/core_sleep_ctrl.md
# core_sleep_ctrl

Sleep/wake controller that sits directly upstream of the core clock gate and produces its enable. It tracks the core's fetch-enable, WFI and wake events. It also counts outstanding instruction and data bus transactions so the gated clock is stopped only when the core is quiescent. It runs on the ungated clock and re-enables the gate on interrupt or debug request.

## Interface
- MAX_OUTSTANDING, 2: max in-flight transactions per bus (OBI req/gnt/rvalid); counter width clog2(MAX_OUTSTANDING+1).
- WAKE_DELAY, 2: cycles the clock runs in WAKE before fetch is re-enabled; 0 is treated as 1.
- clk_i  in  1  ungated clock.
- rst_ni  in  1  reset; one clock, reset asynchronous and active-low.
- fetch_enable_i  in  1  external fetch enable; captured sticky once high.
- wfi_i  in  1  core has retired WFI and requests sleep (level).
- irq_pending_i  in  1  any enabled interrupt pending.
- debug_req_i  in  1  debug request.
- instr_req_i / instr_gnt_i / instr_rvalid_i  in  1 each  instruction bus handshake.
- data_req_i / data_gnt_i / data_rvalid_i  in  1 each  data bus handshake.
- clock_en_o  out  1  registered enable to the clock gate's en_i.
- core_sleep_o  out  1  core clock is stopped.
- fetch_enable_o  out  1  fetch enable to core.
- wake_o  out  1  one-cycle pulse on each SLEEP→WAKE transition.
- err_o  out  1  sticky protocol error (counter over/underflow).

## Operation
- Outstanding counters, one per bus:
  - +1 on req&gnt, −1 on rvalid; both in the same cycle leaves the count unchanged.
  - req&gnt at MAX_OUTSTANDING without rvalid: count holds, err_o set.
  - rvalid at 0: count holds at 0, err_o set.
  - err_o clears only on reset.
- "quiescent" = both counts 0 and instr_req_i=0 and data_req_i=0.
- "wake" = irq_pending_i | debug_req_i.
- Outputs are registered; each is a decode of the next state.
- FSM states, transitions and outputs:
  - OFF (reset): clock_en_o=0, core_sleep_o=1, fetch_enable_o=0. Goes to WAKE when fetch_enable_i=1.
  - WAKE: clock_en_o=1, core_sleep_o=0, fetch_enable_o=0. Delay counter loads max(WAKE_DELAY,1) on entry; goes to RUN when it reaches 1.
  - RUN: clock_en_o=1, fetch_enable_o=1. wfi_i & !wake → DRAIN.
  - DRAIN: clock_en_o=1, fetch_enable_o=0. wake → RUN (has priority). Otherwise quiescent → SLEEP.
  - SLEEP: clock_en_o=0, core_sleep_o=1. wake → WAKE, with wake_o=1 for that one cycle.
- Sticky fetch enable: once captured, fetch_enable_i dropping has no effect until reset.
- wfi_i in WAKE is ignored.
- Counters keep running in every state. Responses arriving during SLEEP must not occur; if one does, err_o is set (a 0 count can only underflow).

## Timing
- Reset values: clock_en_o=0, core_sleep_o=1, fetch_enable_o=0, wake_o=0, err_o=0, counters=0, state OFF.
- Wake event sampled at edge N:
  - clock_en_o=1 after edge N.
  - The gate latches it on the following negedge, so the first gated edge is N+1.
  - fetch_enable_o=1 after edge N+max(WAKE_DELAY,1).
- Sleep entry, quiescent seen in DRAIN at edge N: clock_en_o=0 after edge N; the last gated edge is N.
- A wake event in the same cycle quiescent is seen: DRAIN→RUN; the clock never stops.
- A wake event in the same cycle as wfi_i in RUN: stay in RUN.
- Reset asserted mid-operation: all outputs take reset values immediately (asynchronously). fetch_enable_i must be seen again.

## Structure
- Package core_sleep_pkg holds:
  - state enum typedef (OFF, WAKE, RUN, DRAIN, SLEEP);
  - default constants for MAX_OUTSTANDING and WAKE_DELAY.
- Sub-module core_sleep_otx_cnt: the outstanding counter with its error flag, instantiated once per bus.

## Test plan
- Reset, then fetch_enable_i=1 at cycle 3 with WAKE_DELAY=2 → clock_en_o=1 from cycle 4; fetch_enable_o=1 from cycle 6; core_sleep_o=0.
- In RUN with 2 data transactions outstanding, wfi_i=1 → DRAIN, clock_en_o stays 1. After the second rvalid, clock_en_o=0 and core_sleep_o=1 next cycle.
- In SLEEP, irq_pending_i=1 for one cycle → wake_o pulse, clock_en_o=1 next cycle, RUN after WAKE_DELAY cycles.
- In DRAIN, debug_req_i rises in the same cycle the last rvalid arrives → RUN; clock_en_o never drops.
- Simultaneous instr gnt and rvalid with count 1 → count stays 1. A third gnt at count 2 with MAX_OUTSTANDING=2 → err_o=1, count 2.
- rst_ni low mid-SLEEP and mid-DRAIN → OFF, all outputs at reset values. fetch_enable_i held high through reset → WAKE on the first cycle after release.
